// File: rtl/if_redirect_ctrl.sv
// Fetch-stage control sequencer: PC write/select, redirect address, pipeline flush/hold, statistics.
// Latency: redirect and stall controls are combinational in the cycle they arrive; ctrl_state is registered.
// Backpressure: hazard_stall holds PC and IF/ID; an accepted mispredict overrides the stall and redirects.
//
// Ports:
//   clk, rst (async active-low)
//   hazard_stall                               load-use hold request
//   mem_branch, miss_predict, mem_is_taken     MEM-stage branch resolution
//   mem_pc, t_addr                             MEM-stage branch PC and resolved target
//   PCWrite, PCSrc, redirect_pc                PC load enable / source select / corrected address
//   IF_ID_Write, flush[2:0]                    IF/ID hold, bubble insert (bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM)
//   ctrl_state                                 0 BOOT, 1 RUN, 2 STALL, 3 DRAIN
//   br_cnt, mp_cnt, stall_cnt                  saturating statistics
module if_redirect_ctrl #(
    parameter int BOOT_CYC    = 4,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             mem_branch,
    input  logic             miss_predict,
    input  logic             mem_is_taken,
    input  logic [31:0]      mem_pc,
    input  logic [31:0]      t_addr,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [31:0]      redirect_pc,
    output logic             IF_ID_Write,
    output logic [2:0]       flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_INIT  = 8'(BOOT_CYC - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_DEPTH - 1);

    state_t           state_q, state_d;
    logic [7:0]       boot_q, boot_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] mp_q, mp_d;
    logic [CNT_W-1:0] st_q, st_d;

    // Mispredicts are only trusted while the pipe holds right-path work;
    // in DRAIN the MEM stage carries wrong-path instructions already squashed.
    logic accept;
    assign accept = miss_predict && ((state_q == ST_RUN) || (state_q == ST_STALL));

    always_comb begin
        state_d     = state_q;
        boot_d      = boot_q;
        drain_d     = drain_q;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        PCSrc       = 1'b0;
        flush       = 3'b000;

        unique case (state_q)
            ST_BOOT: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                flush       = 3'b001;
                if (boot_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q - 8'd1;
                end
            end
            ST_RUN, ST_STALL: begin
                if (accept) begin
                    // Redirect beats a load-use stall: the stalled instruction is wrong-path anyway.
                    PCSrc   = 1'b1;
                    flush   = 3'b111;
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else if (hazard_stall) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    flush       = 3'b010;
                    state_d     = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (hazard_stall) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    flush       = 3'b010;
                end
                // Drain length is fixed regardless of stalls.
                if (drain_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Address mux forced to zero while reset is held so the PC path sees a clean value.
    always_comb begin
        redirect_pc = mem_pc + 32'd4;
        if (!rst) begin
            redirect_pc = 32'h0;
        end else if (accept && mem_is_taken) begin
            redirect_pc = t_addr;
        end
    end

    // Saturating statistics.
    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        st_d = st_q;
        if (mem_branch && (state_q != ST_BOOT) && (br_q != '1)) begin
            br_d = br_q + CNT_W'(1);
        end
        if (accept && (mp_q != '1)) begin
            mp_d = mp_q + CNT_W'(1);
        end
        if ((state_q == ST_STALL) && (st_q != '1)) begin
            st_d = st_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            boot_q  <= BOOT_INIT;
            drain_q <= 4'd0;
            br_q    <= '0;
            mp_q    <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            drain_q <= drain_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
            st_q    <= st_d;
        end
    end

    assign ctrl_state = state_q;
    assign br_cnt     = br_q;
    assign mp_cnt     = mp_q;
    assign stall_cnt  = st_q;

endmodule

// File: tb/tb_if_redirect_ctrl.sv
module tb_if_redirect_ctrl;

    localparam int BC = 4;
    localparam int FD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        mem_branch = 1'b0;
    logic        miss_predict = 1'b0;
    logic        mem_is_taken = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic [31:0] t_addr = 32'h0;

    logic        pcw_a, src_a, ifw_a, pcw_b, src_b, ifw_b;
    logic [31:0] rpc_a, rpc_b;
    logic [2:0]  fl_a, fl_b;
    logic [1:0]  cs_a, cs_b;
    logic [15:0] br_a, mp_a, st_a;
    logic [3:0]  br_b, mp_b, st_b;

    if_redirect_ctrl #(.BOOT_CYC(BC), .FLUSH_DEPTH(FD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .mem_branch(mem_branch),
        .miss_predict(miss_predict), .mem_is_taken(mem_is_taken), .mem_pc(mem_pc), .t_addr(t_addr),
        .PCWrite(pcw_a), .PCSrc(src_a), .redirect_pc(rpc_a), .IF_ID_Write(ifw_a), .flush(fl_a),
        .ctrl_state(cs_a), .br_cnt(br_a), .mp_cnt(mp_a), .stall_cnt(st_a)
    );

    if_redirect_ctrl #(.BOOT_CYC(BC), .FLUSH_DEPTH(FD), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .mem_branch(mem_branch),
        .miss_predict(miss_predict), .mem_is_taken(mem_is_taken), .mem_pc(mem_pc), .t_addr(t_addr),
        .PCWrite(pcw_b), .PCSrc(src_b), .redirect_pc(rpc_b), .IF_ID_Write(ifw_b), .flush(fl_b),
        .ctrl_state(cs_b), .br_cnt(br_b), .mp_cnt(mp_b), .stall_cnt(st_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: phase name plus cycles remaining in timed phases; unbounded event totals.
    int          m_mode;   // 0 boot, 1 run, 2 stall, 3 drain
    int          m_left;
    int unsigned m_br, m_mp, m_st;

    function automatic logic [31:0] sat(int unsigned v, int w);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_counters();
        chk("br_cnt",    32'(br_a), sat(m_br, 16));
        chk("mp_cnt",    32'(mp_a), sat(m_mp, 16));
        chk("stall_cnt", 32'(st_a), sat(m_st, 16));
        chk("br_cnt4",   32'(br_b), sat(m_br, 4));
        chk("mp_cnt4",   32'(mp_b), sat(m_mp, 4));
        chk("stall_cnt4",32'(st_b), sat(m_st, 4));
    endtask

    // Asserts reset away from a clock edge, checks the immediate effect, releases after the next rising edge.
    task automatic do_reset();
        rst = 1'b0;
        mem_pc = $urandom;
        #1;
        m_mode = 0; m_left = BC; m_br = 0; m_mp = 0; m_st = 0;
        chk("rst_state",  32'(cs_a), 32'd0);
        chk("rst_state4", 32'(cs_b), 32'd0);
        chk("rst_pcw",    32'(pcw_a), 32'd0);
        chk("rst_src",    32'(src_a), 32'd0);
        chk("rst_ifw",    32'(ifw_a), 32'd0);
        chk("rst_flush",  32'(fl_a), 32'd1);
        chk("rst_rpc",    rpc_a, 32'd0);
        chk_counters();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1.
    task automatic cyc(bit hs, bit mb, bit mp, bit tk, logic [31:0] pc, logic [31:0] ta);
        bit          acc;
        bit          e_pcw, e_ifw, e_src;
        logic [2:0]  e_fl;
        logic [31:0] e_rpc;
        hazard_stall = hs; mem_branch = mb; miss_predict = mp;
        mem_is_taken = tk; mem_pc = pc; t_addr = ta;
        @(negedge clk);
        acc = mp && (m_mode == 1 || m_mode == 2);
        if (m_mode == 0)  begin e_pcw = 0; e_ifw = 0; e_src = 0; e_fl = 3'b001; end
        else if (acc)     begin e_pcw = 1; e_ifw = 1; e_src = 1; e_fl = 3'b111; end
        else if (hs)      begin e_pcw = 0; e_ifw = 0; e_src = 0; e_fl = 3'b010; end
        else              begin e_pcw = 1; e_ifw = 1; e_src = 0; e_fl = 3'b000; end
        e_rpc = (acc && tk) ? ta : pc + 32'd4;
        chk("state",   32'(cs_a),  32'(m_mode));
        chk("pcwrite", 32'(pcw_a), 32'(e_pcw));
        chk("ifid_wr", 32'(ifw_a), 32'(e_ifw));
        chk("pcsrc",   32'(src_a), 32'(e_src));
        chk("flush",   32'(fl_a),  32'(e_fl));
        chk("rpc",     rpc_a,      e_rpc);
        chk("state4",  32'(cs_b),  32'(m_mode));
        chk("pcw4",    32'({pcw_b, ifw_b, src_b, fl_b}), 32'({e_pcw, e_ifw, e_src, e_fl}));
        chk("rpc4",    rpc_b,      e_rpc);
        chk_counters();
        if (m_mode != 0 && mb) m_br++;
        if (acc) m_mp++;
        if (m_mode == 2) m_st++;
        case (m_mode)
            0: begin m_left--; if (m_left == 0) m_mode = 1; end
            1, 2: begin
                if (acc) begin m_mode = 3; m_left = FD; end
                else m_mode = hs ? 2 : 1;
            end
            default: begin m_left--; if (m_left == 0) m_mode = 1; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h1000, 32'h0);
    endtask

    initial begin
        #2;
        do_reset();
        // Boot window then first RUN cycle.
        idle(BC + 1);
        // Two-cycle load-use stall, then resume.
        cyc(1, 0, 0, 0, 32'h200, 32'h0);
        cyc(1, 0, 0, 0, 32'h200, 32'h0);
        idle(2);
        // Taken mispredict to 0x80, drain, back to run.
        cyc(0, 1, 1, 1, 32'h300, 32'h0000_0080);
        idle(FD + 1);
        // Not-taken mispredict at top of address space wraps to zero.
        cyc(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h1234_5678);
        idle(FD);
        // Mispredict during STALL with stall still asserted: redirect wins.
        cyc(1, 0, 0, 0, 32'h400, 32'h0);
        cyc(1, 1, 1, 1, 32'h400, 32'h0000_0900);
        // Mispredict pulsed in DRAIN is ignored, stall in DRAIN gates outputs.
        cyc(0, 1, 1, 1, 32'h500, 32'h0000_0A00);
        cyc(1, 0, 1, 0, 32'h504, 32'h0);
        idle(2);
        // Branch count saturation on the narrow instance.
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 32'h600 + 32'(4 * i), 32'h0);
        // Reset in the middle of a drain.
        cyc(0, 0, 1, 1, 32'h700, 32'h0000_0B00);
        cyc(0, 0, 0, 0, 32'h704, 32'h0);
        #2;
        do_reset();
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 199) == 0) begin
                #1;
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) < 2, 1'($urandom), pc, $urandom & 32'hFFFF_FFFC);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_redirect_ctrl.md
Name: if_redirect_ctrl

Overview:
- Control sequencer for the instruction-fetch stage.
- Generates PC write enable, PC source select, redirect address and per-register pipeline flush/hold controls from three inputs: load-use hazards, MEM-stage misprediction reports and a post-reset boot window.
- Masks wrong-path misprediction reports during drain and keeps saturating branch, mispredict and stall statistics.
- Sits between the hazard unit, the MEM-stage branch resolution and the fetch-stage PC, PC_MUX and IF/ID register.

Parameters:
- BOOT_CYC, 4: cycles PC is held at reset value after reset release (instruction memory settle); range 1..255.
- FLUSH_DEPTH, 3: DRAIN length in cycles after a redirect; range 1..15.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hazard_stall  in  1  load-use stall request from the hazard unit.
- mem_branch  in  1  MEM-stage instruction is a conditional branch.
- miss_predict  in  1  MEM-stage branch prediction was wrong.
- mem_is_taken  in  1  MEM-stage branch actual outcome.
- mem_pc  in  32  PC of the MEM-stage branch.
- t_addr  in  32  resolved branch target of the MEM-stage branch.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  1  1 = PC loads redirect_pc instead of the predicted next PC.
- redirect_pc  out  32  corrected fetch address.
- IF_ID_Write  out  1  IF/ID register load enable.
- flush  out  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM: load a bubble.
- ctrl_state  out  2  0 BOOT, 1 RUN, 2 STALL, 3 DRAIN.
- br_cnt  out  CNT_W  resolved conditional branches.
- mp_cnt  out  CNT_W  accepted mispredictions.
- stall_cnt  out  CNT_W  cycles spent in STALL.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, boot counter=BOOT_CYC-1, drain counter=0, all statistics counters=0.
- Reset output values: PCWrite=0, PCSrc=0, redirect_pc=0, IF_ID_Write=0, flush=3'b001, ctrl_state=0.
- Reset asserted mid-operation aborts any state immediately.
- "Accepted redirect" = miss_predict=1 while state is RUN or STALL. It is purely combinational in the same cycle (Mealy, zero latency):
  - PCSrc=1, PCWrite=1, IF_ID_Write=1, flush=3'b111.
  - redirect_pc = mem_is_taken ? t_addr : mem_pc+4, 32-bit wrap (0xFFFFFFFC+4=0).
  - Next state DRAIN, drain counter=FLUSH_DEPTH-1.
  - A redirect has priority over hazard_stall.
- When no redirect is accepted, redirect_pc=mem_pc+4 and PCSrc=0.
- BOOT:
  - Outputs: PCWrite=0, IF_ID_Write=0, flush=3'b001.
  - Counter decrements each cycle; at 0, next state RUN. Exactly BOOT_CYC cycles in BOOT.
  - All inputs ignored.
- RUN:
  - No hazard: PCWrite=1, IF_ID_Write=1, flush=0.
  - hazard_stall=1: PCWrite=0, IF_ID_Write=0, flush=3'b010 in the same cycle; next state STALL.
- STALL:
  - Stall outputs held while hazard_stall=1.
  - hazard_stall=0 gives RUN outputs combinationally; next state RUN.
  - stall_cnt increments once per STALL cycle.
- DRAIN:
  - miss_predict is masked: no redirect, no mp_cnt increment.
  - hazard_stall gates outputs exactly as in RUN, but the drain counter still decrements.
  - At counter 0, next state RUN. Exactly FLUSH_DEPTH cycles in DRAIN.
- Statistics counters:
  - br_cnt increments on every cycle with mem_branch=1 outside BOOT, including in DRAIN.
  - mp_cnt increments only on an accepted redirect.
  - All counters saturate at 2^CNT_W-1; no wrap.
  - A redirect and a branch in the same cycle increment both counters.
- ctrl_state is the registered state.

Test Plan:
- Reset with BOOT_CYC=4 -> PCWrite=0 for exactly 4 cycles after rst release, flush=001; PCWrite=1 and ctrl_state=1 in cycle 5.
- RUN, hazard_stall high for 2 cycles -> PCWrite=0, IF_ID_Write=0, flush=010 for 2 cycles; stall_cnt=2; RUN resumes the next cycle.
- RUN, miss_predict=1, mem_is_taken=1, t_addr=0x00000080 -> same cycle PCSrc=1, redirect_pc=0x80, flush=111; ctrl_state=3 for 3 cycles, then 1; mp_cnt=1.
- miss_predict=1, mem_is_taken=0, mem_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- miss_predict and hazard_stall together in STALL -> redirect wins, PCWrite=1. miss_predict pulsed during DRAIN -> PCSrc stays 0, mp_cnt unchanged.
- CNT_W=4, 20 cycles with mem_branch=1 -> br_cnt holds at 15; rst pulsed low mid-DRAIN -> ctrl_state=0 and all counters 0 immediately.
